// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : Buffered UART transmitter. Bytes are accepted into a
//               power-of-two FIFO and shifted out as 8-bit frames (start bit,
//               8 data bits LSB first, optional parity bit, one stop bit).
//               Queued bytes go out back-to-back with no idle gap.
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous active-high reset
//               tx_vld   - tx_data valid this cycle
//               tx_data  - byte to transmit
//               tx_rdy   - a byte is accepted this cycle (FIFO not full)
//               tx       - serial line, idle high, driven from a flop
//               busy     - a frame is in progress
//               fifo_cnt - bytes waiting in the FIFO (excludes byte on the line)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tx_vld,
    input  logic [7:0]                    tx_data,
    output logic                          tx_rdy,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int                 c_addr_w   = $clog2(FIFO_DEPTH);
    localparam int                 c_baud_w   = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
    localparam logic [c_addr_w-1:0] c_ptr_one   = c_addr_w'(1);
    localparam logic [c_addr_w:0]   c_cnt_one   = (c_addr_w + 1)'(1);
    localparam logic [c_addr_w:0]   c_cnt_full  = (c_addr_w + 1)'(FIFO_DEPTH);
    localparam bit                  c_par_en    = (PARITY_EN != 0);
    localparam bit                  c_par_odd   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_addr_w:0]   r_cnt;

    // ------------------------------------------------------------------
    // Transmit state
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]          r_bit;
    logic [7:0]          r_shift;
    logic                r_par;
    logic                r_tx;
    logic                r_busy;

    logic w_push;
    logic w_pop;
    logic w_baud_done;

    assign tx_rdy      = (r_cnt != c_cnt_full);
    assign w_push      = tx_vld & tx_rdy;
    assign w_baud_done = (r_baud == c_baud_last);
    // The head is taken either from idle or at the very end of a stop bit,
    // the latter giving back-to-back frames with no idle cycle between them.
    assign w_pop       = (r_cnt != '0) &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign fifo_cnt = r_cnt;

    // Storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer. r_shift holds the data bits not yet placed on the
    // line; r_par is computed once when the byte is loaded.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_par   <= (^r_mem[r_rd_ptr]) ^ c_par_odd;
                        r_baud  <= '0;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            if (c_par_en) begin
                                r_tx    <= r_par;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                PARITY: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_par   <= (^r_mem[r_rd_ptr]) ^ c_par_odd;
                            r_tx    <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_baud_one;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx. Three instances
//               share clock, reset and data: no parity, even parity, odd
//               parity (CLKS_PER_BIT=4, FIFO_DEPTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld0 = 1'b0, vld1 = 1'b0, vld2 = 1'b0;
    logic [7:0] data = 8'h00;
    logic       rdy0, rdy1, rdy2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic [4:0] cnt0, cnt1, cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst(rst), .tx_vld(vld0), .tx_data(data),
        .tx_rdy(rdy0), .tx(tx0), .busy(busy0), .fifo_cnt(cnt0));

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_pe (
        .clk(clk), .rst(rst), .tx_vld(vld1), .tx_data(data),
        .tx_rdy(rdy1), .tx(tx1), .busy(busy1), .fifo_cnt(cnt1));

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_po (
        .clk(clk), .rst(rst), .tx_vld(vld2), .tx_data(data),
        .tx_rdy(rdy2), .tx(tx2), .busy(busy2), .fifo_cnt(cnt2));

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? tx0 : (sel == 1) ? tx1 : tx2;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    endfunction

    task automatic set_vld(input int sel, input logic v);
        case (sel)
            0:       vld0 = v;
            1:       vld1 = v;
            default: vld2 = v;
        endcase
    endtask

    // Line bits in transmit order, index 0 first.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit pe, input bit pb);
        logic [10:0] f;
        f      = '0;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (pe) begin
            f[9]  = pb;
            f[10] = 1'b1;
        end else begin
            f[9]  = 1'b1;
        end
        return f;
    endfunction

    // Called at the negedge that shows the first start-bit cycle; returns at
    // the negedge just after the last stop cycle.
    task automatic check_frame(input string tag, input int sel, input logic [10:0] f, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < CPB; c++) begin
                check_value($sformatf("%s_tx_b%0d_c%0d", tag, b, c), get_tx(sel), f[b]);
                check_value($sformatf("%s_busy_b%0d", tag, b), get_busy(sel), 1'b1);
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_start(input string tag, input int sel, input int budget);
        int n = 0;
        while (get_tx(sel) !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_start_seen"}, get_tx(sel), 1'b0);
    endtask

    // Pulse tx_vld for one cycle; returns at the negedge of the first start cycle.
    task automatic write_one(input int sel, input logic [7:0] b);
        set_vld(sel, 1'b1);
        data = b;
        @(negedge clk);
        set_vld(sel, 1'b0);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag, input int sel);
        check_value({tag, "_idle_tx"}, get_tx(sel), 1'b1);
        check_value({tag, "_idle_busy"}, get_busy(sel), 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int busies;

        repeat (2) @(negedge clk);
        // Reset state
        check_value("rst_tx0", tx0, 1'b1);
        check_value("rst_busy0", busy0, 1'b0);
        check_value("rst_cnt0", cnt0, 5'd0);
        check_value("rst_rdy0", rdy0, 1'b1);
        check_value("rst_tx1", tx1, 1'b1);
        check_value("rst_tx2", tx2, 1'b1);

        // Single byte 0xA5 pushed on the first edge after reset release
        rst  = 1'b0;
        vld0 = 1'b1;
        data = 8'hA5;
        @(negedge clk);
        vld0 = 1'b0;
        check_value("lat_cnt", cnt0, 5'd1);
        check_value("lat_tx", tx0, 1'b1);
        check_value("lat_busy", busy0, 1'b0);
        @(negedge clk);
        check_value("a5_cnt_after_pop", cnt0, 5'd0);
        check_frame("a5", 0, 11'b00_1010_0101_0 | 11'b010_0000_0000, 10);
        check_idle("a5", 0);
        check_value("a5_idle_cnt", cnt0, 5'd0);

        // Parity 0x07: even parity bit 1, odd parity bit 0
        write_one(1, 8'h07);
        check_frame("par_even", 1, make_frame(8'h07, 1'b1, 1'b1), 11);
        check_idle("par_even", 1);
        write_one(2, 8'h07);
        check_frame("par_odd", 2, make_frame(8'h07, 1'b1, 1'b0), 11);
        check_idle("par_odd", 2);

        // Back-to-back 0x55, 0xAA; second push coincides with first pop
        vld0 = 1'b1;
        data = 8'h55;
        @(negedge clk);
        data = 8'hAA;
        @(negedge clk);
        vld0 = 1'b0;
        check_value("b2b_cnt", cnt0, 5'd1);
        check_frame("b2b_55", 0, make_frame(8'h55, 1'b0, 1'b0), 10);
        check_frame("b2b_aa", 0, make_frame(8'hAA, 1'b0, 1'b0), 10);
        check_idle("b2b", 0);

        // Streaming: tx_vld high 20 cycles with 0x00..0x13
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    int exp_cnt;
                    exp_cnt = (k == 0) ? 0 : (k == 1) ? 1 : ((k - 1 > DEPTH) ? DEPTH : k - 1);
                    check_value($sformatf("fill_cnt_%0d", k), cnt0, exp_cnt);
                    check_value($sformatf("fill_rdy_%0d", k), rdy0, (exp_cnt != DEPTH));
                    vld0 = 1'b1;
                    data = 8'(k);
                    @(negedge clk);
                end
                vld0 = 1'b0;
                check_value("fill_cnt_end", cnt0, 5'd16);
            end
            begin
                wait_start("fill", 0, 5);
                for (int i = 0; i < 17; i++) begin
                    check_frame($sformatf("fill_b%0d", i), 0, make_frame(8'(i), 1'b0, 1'b0), 10);
                end
                check_idle("fill", 0);
                check_value("fill_drain_cnt", cnt0, 5'd0);
            end
        join

        // Push lands on the same edge that pops the last queued byte
        vld0 = 1'b1;
        data = 8'h11;
        @(negedge clk);
        data = 8'h22;
        @(negedge clk);
        vld0 = 1'b0;
        fork
            begin
                check_frame("pp_11", 0, make_frame(8'h11, 1'b0, 1'b0), 10);
                check_frame("pp_22", 0, make_frame(8'h22, 1'b0, 1'b0), 10);
                check_frame("pp_33", 0, make_frame(8'h33, 1'b0, 1'b0), 10);
                check_idle("pp", 0);
            end
            begin
                repeat (39) @(negedge clk);
                check_value("pp_cnt_before", cnt0, 5'd1);
                vld0 = 1'b1;
                data = 8'h33;
                @(negedge clk);
                vld0 = 1'b0;
                check_value("pp_cnt_same", cnt0, 5'd1);
                repeat (40) @(negedge clk);
                check_value("pp_cnt_last", cnt0, 5'd0);
            end
        join

        // Reset at cycle 15 of a frame with 3 bytes queued
        vld0 = 1'b1;
        data = 8'h00;
        @(negedge clk);
        data = 8'h01;
        @(negedge clk);
        data = 8'h02;
        @(negedge clk);
        data = 8'h03;
        @(negedge clk);
        vld0 = 1'b0;
        check_value("rstmid_cnt", cnt0, 5'd3);
        repeat (13) @(negedge clk);
        check_value("rstmid_tx_before", tx0, 1'b0);
        check_value("rstmid_busy_before", busy0, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_value("rstmid_tx", tx0, 1'b1);
        check_value("rstmid_busy", busy0, 1'b0);
        check_value("rstmid_cnt0", cnt0, 5'd0);
        check_value("rstmid_rdy", rdy0, 1'b1);
        @(negedge clk);
        rst    = 1'b0;
        lows   = 0;
        busies = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx0 !== 1'b1) lows++;
            if (busy0 !== 1'b0) busies++;
        end
        check_value("rstmid_no_low", lows, 0);
        check_value("rstmid_no_busy", busies, 0);
        check_value("rstmid_cnt_after", cnt0, 5'd0);

        // New write after reset recovery
        write_one(0, 8'hC3);
        check_frame("post_rst", 0, make_frame(8'hC3, 1'b0, 1'b0), 10);
        check_idle("post_rst", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
